// File: rtl/aes_key_expansion.sv
// Iterative AES-128 key schedule: one round key per clock, 11 round keys held
// in a flat 1408-bit register until the next accepted start.
module aes_key_expansion (
    input  logic            clk,
    input  logic            rst,
    input  logic [127:0]    key,
    input  logic            start,
    output logic [1407:0]   expanded_key,
    output logic            busy,
    output logic            finish
);

    typedef enum logic {
        IDLE,
        EXPAND
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      round_q, round_d;
    logic [7:0]      rcon_q, rcon_d;
    logic [1407:0]   ek_q, ek_d;
    logic            finish_q, finish_d;

    logic [3:0]      prev_idx;
    logic [127:0]    prev_rk;
    logic [31:0]     rot_word;
    logic [31:0]     sub_word;
    logic [31:0]     t_word;
    logic [31:0]     n0, n1, n2, n3;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box built from the GF(2^8) inverse (x^254) followed by the affine map,
    // which keeps the design free of a 256-entry constant table.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    assign prev_idx = round_q - 4'd1;
    assign prev_rk  = ek_q[{prev_idx, 7'd0} +: 128];
    assign rot_word = {prev_rk[23:0], prev_rk[31:24]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            assign sub_word[gi*8 +: 8] = sbox(rot_word[gi*8 +: 8]);
        end
    endgenerate

    assign t_word = sub_word ^ {rcon_q, 24'h0};
    assign n0     = prev_rk[127:96] ^ t_word;
    assign n1     = prev_rk[95:64]  ^ n0;
    assign n2     = prev_rk[63:32]  ^ n1;
    assign n3     = prev_rk[31:0]   ^ n2;

    always_comb begin
        state_d  = state_q;
        round_d  = round_q;
        rcon_d   = rcon_q;
        ek_d     = ek_q;
        finish_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ek_d[127:0] = key;
                    round_d     = 4'd1;
                    rcon_d      = 8'h01;
                    state_d     = EXPAND;
                end
            end
            EXPAND: begin
                ek_d[{round_q, 7'd0} +: 128] = {n0, n1, n2, n3};
                round_d = round_q + 4'd1;
                rcon_d  = xtime(rcon_q);
                if (round_q == 4'd10) begin
                    finish_d = 1'b1;
                    round_d  = 4'd0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            round_q  <= 4'd0;
            rcon_q   <= 8'h00;
            ek_q     <= '0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            round_q  <= round_d;
            rcon_q   <= rcon_d;
            ek_q     <= ek_d;
            finish_q <= finish_d;
        end
    end

    assign expanded_key = ek_q;
    assign busy         = (state_q == EXPAND);
    assign finish       = finish_q;

endmodule

// File: tb/tb_aes_key_expansion.sv
// Directed bench for aes_key_expansion using FIPS-197 and all-zero key vectors.
module tb_aes_key_expansion;

    logic            clk;
    logic            rst;
    logic [127:0]    key;
    logic            start;
    logic [1407:0]   expanded_key;
    logic            busy;
    logic            finish;

    int n_checks;
    int n_fail;

    localparam logic [127:0] KEY_A1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A1_SLOT1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A1_SLOT10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] Z_SLOT1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Z_SLOT10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    aes_key_expansion dut (
        .clk          (clk),
        .rst          (rst),
        .key          (key),
        .start        (start),
        .expanded_key (expanded_key),
        .busy         (busy),
        .finish       (finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    function automatic logic [127:0] slot(input int r);
        return expanded_key[r*128 +: 128];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts k on the next edge, then waits for finish; lat counts edges after accept.
    task automatic run_key(input logic [127:0] k, output int lat);
        start = 1'b1;
        key   = k;
        tick();
        start = 1'b0;
        lat   = 0;
        while (!finish && lat < 30) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int extra_fin;
        int gap_low;
        logic [127:0] zero_w;
        n_checks = 0;
        n_fail   = 0;
        zero_w   = '0;
        rst   = 1'b1;
        start = 1'b0;
        key   = '0;

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            start = 1'($urandom_range(0, 1));
            key   = {$urandom, $urandom, $urandom, $urandom};
            tick();
            check_eq("rst_ek_or", {127'd0, |expanded_key}, zero_w);
            check_eq("rst_busy", {127'd0, busy}, zero_w);
            check_eq("rst_finish", {127'd0, finish}, zero_w);
        end
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();

        // FIPS-197 A.1 with slot-1 timing
        start = 1'b1;
        key   = KEY_A1;
        tick();
        start = 1'b0;
        key   = '0;
        check_eq("a1_busy_t0", {127'd0, busy}, 128'd1);
        check_eq("a1_slot0", slot(0), KEY_A1);
        tick();
        check_eq("a1_slot1_t1", slot(1), A1_SLOT1);
        lat = 1;
        while (!finish && lat < 30) begin
            tick();
            lat++;
        end
        check_eq("a1_latency", 128'(lat), 128'd10);
        check_eq("a1_busy_fin", {127'd0, busy}, zero_w);
        check_eq("a1_slot10", slot(10), A1_SLOT10);
        tick();
        check_eq("a1_finish_pulse", {127'd0, finish}, zero_w);

        // All-zero key
        run_key(128'd0, lat);
        check_eq("zero_latency", 128'(lat), 128'd10);
        check_eq("zero_slot1", slot(1), Z_SLOT1);
        check_eq("zero_slot10", slot(10), Z_SLOT10);
        tick();

        // Start while busy must be ignored
        start = 1'b1;
        key   = KEY_A1;
        tick();
        start = 1'b0;
        lat   = 0;
        while (!finish && lat < 30) begin
            tick();
            lat++;
            if (lat == 4) begin
                start = 1'b1;
                key   = '0;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check_eq("busy_start_latency", 128'(lat), 128'd10);
        check_eq("busy_start_slot1", slot(1), A1_SLOT1);
        check_eq("busy_start_slot10", slot(10), A1_SLOT10);
        extra_fin = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (finish) extra_fin++;
        end
        check_eq("busy_start_no_2nd_finish", 128'(extra_fin), zero_w);

        // Back-to-back: second start issued in the finish cycle
        run_key(KEY_A1, lat);
        check_eq("b2b_lat1", 128'(lat), 128'd10);
        check_eq("b2b_a1_slot10", slot(10), A1_SLOT10);
        start   = 1'b1;
        key     = '0;
        gap_low = 0;
        tick();
        start = 1'b0;
        check_eq("b2b_slot0_t11", slot(0), zero_w);
        lat = 0;
        if (!busy && !finish) gap_low++;
        while (!finish && lat < 30) begin
            tick();
            lat++;
            if (!busy && !finish) gap_low++;
        end
        check_eq("b2b_lat2", 128'(lat), 128'd10);
        check_eq("b2b_idle_gap", 128'(gap_low), zero_w);
        check_eq("b2b_zero_slot10", slot(10), Z_SLOT10);
        tick();

        // Asynchronous reset in the middle of an expansion
        start = 1'b1;
        key   = KEY_A1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        check_eq("midrst_ek_async", {127'd0, |expanded_key}, zero_w);
        check_eq("midrst_busy_async", {127'd0, busy}, zero_w);
        @(negedge clk);
        rst = 1'b0;
        extra_fin = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (finish) extra_fin++;
        end
        check_eq("midrst_no_finish", 128'(extra_fin), zero_w);
        check_eq("midrst_ek_zero", {127'd0, |expanded_key}, zero_w);
        run_key(KEY_A1, lat);
        check_eq("midrst_rerun_lat", 128'(lat), 128'd10);
        check_eq("midrst_rerun_slot1", slot(1), A1_SLOT1);
        check_eq("midrst_rerun_slot10", slot(10), A1_SLOT10);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
